// File: rtl/mem_fifo_loader.sv
// Stages up to DEPTH words in a local buffer, then on a start edge streams
// them in write order into a downstream FIFO, honouring its full flag.
module mem_fifo_loader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             rst1,
    input  logic [WIDTH-1:0] port_A,
    input  logic             W_en,
    input  logic             s_sig,
    input  logic             wfull,
    output logic             winc,
    output logic [WIDTH-1:0] wdata,
    output logic [ADDR:0]    count,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR-1:0]  wr_ptr, rd_ptr;
    logic [ADDR:0]    sent;
    logic             s_prev;
    logic             start_edge;
    logic             wr_ok;
    logic             last_word;

    assign start_edge = s_sig & ~s_prev;
    assign wr_ok      = (state == IDLE) && W_en && (count != FULL_CNT);
    assign last_word  = winc && (sent == count - 1'b1);

    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) state <= IDLE;
        else       state <= state_nxt;
    end

    // A write accepted in the same cycle as the start edge counts toward the transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_edge) state_nxt = ((count != '0) || wr_ok) ? XFER : DONE;
            XFER: if (last_word)  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == XFER);
        done  = (state == DONE);
        winc  = (state == XFER) && !wfull;
        wdata = winc ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            s_prev   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sent     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            s_prev <= s_sig;
            if (W_en && !wr_ok) overflow <= 1'b1;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (winc) begin
                rd_ptr <= rd_ptr + 1'b1;
                sent   <= sent + 1'b1;
            end
            if (state == DONE) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                sent   <= '0;
                count  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= port_A;
    end

endmodule
